// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-port data RAM.
// M0 (core load/store) has default priority. M1 (debug/DMA) is protected by a
// starvation counter and may lock the port for a bounded burst.
// Read data returns one cycle after the granted read command.
module mem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              core_stall
);

  localparam logic [0:0] IDLE  = 1'b0;  // M0 priority
  localparam logic [0:0] LOCK1 = 1'b1;  // M1 owns the port

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);
  localparam bit         BURST_EN   = (MAX_BURST > 1);

  logic [0:0] state;
  logic [3:0] starve_cnt;
  logic [7:0] beat_cnt;
  logic [7:0] beat_inc;

  assign beat_inc = beat_cnt + 8'd1;

  // Grant selection: in LOCK1 only M1 may win; in IDLE M1 wins when alone or starved
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (state == LOCK1) begin
      m1_gnt = m1_req;
    end else begin
      m1_gnt = m1_req && (!m0_req || (starve_cnt == STARVE_MAX));
      m0_gnt = m0_req && !m1_gnt;
    end
  end

  // RAM command mux; idle bus is driven to zero so the RAM sees a clean strobe
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (m0_gnt) begin
      ram_en    = 1'b1;
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
    end else if (m1_gnt) begin
      ram_en    = 1'b1;
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end
  end

  assign core_stall = m0_req && !m0_gnt;
  assign m0_rdata   = m0_rvalid ? ram_rdata : '0;
  assign m1_rdata   = m1_rvalid ? ram_rdata : '0;

  // Read-response tracking, starvation counter and burst-lock state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      beat_cnt   <= '0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
    end else begin
      m0_rvalid <= m0_gnt && !m0_we;
      m1_rvalid <= m1_gnt && !m1_we;

      if (!m1_req || m1_gnt)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 4'd1;

      case (state)
        IDLE: begin
          if (m1_gnt && m1_lock && BURST_EN) begin
            state    <= LOCK1;
            beat_cnt <= 8'd1;
          end
        end
        default: begin
          // Leave the burst when M1 goes quiet, drops lock, or uses its last beat
          if (!m1_req || !m1_lock || (m1_gnt && (beat_inc == BURST_MAX))) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end else if (m1_gnt && (beat_cnt != 8'hFF)) begin
            beat_cnt <= beat_inc;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level reference model and a shadow copy of RAM contents.
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 64;
  localparam int SL = 4;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_en, ram_we, core_stall;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .core_stall(core_stall)
  );

  // Simple synchronous single-port RAM, one-cycle read latency
  logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: '0};
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // ---------------- reference model ----------------
  int            ref_wait;    // cycles M1 has been refused in a row
  bit            ref_owned;   // M1 currently holds the port for a burst
  int            ref_beats;   // M1 grants taken in current burst
  bit            e0, e1;
  logic          x_en, x_we, x_stall;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata;
  logic          x_rv0, x_rv1;
  logic [DW-1:0] x_rd0, x_rd1;
  logic [DW-1:0] ref_mem [int];

  function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  task automatic model_eval();
    if (ref_owned) begin
      e1 = m1_req;
      e0 = 1'b0;
    end else begin
      e1 = m1_req && (!m0_req || ref_wait >= SL);
      e0 = m0_req && !e1;
    end
    x_en    = e0 || e1;
    x_we    = e0 ? m0_we    : (e1 ? m1_we    : 1'b0);
    x_addr  = e0 ? m0_addr  : (e1 ? m1_addr  : '0);
    x_wdata = e0 ? m0_wdata : (e1 ? m1_wdata : '0);
    x_stall = m0_req && !e0;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge
  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst) begin
      ref_wait = 0; ref_owned = 0; ref_beats = 0;
      x_rv0 = 0; x_rv1 = 0; x_rd0 = '0; x_rd1 = '0;
    end else begin
      x_rv0 = e0 && !m0_we;
      x_rd0 = x_rv0 ? rd_mem(m0_addr) : '0;
      x_rv1 = e1 && !m1_we;
      x_rd1 = x_rv1 ? rd_mem(m1_addr) : '0;
      if (!m1_req || e1) ref_wait = 0;
      else if (ref_wait < SL) ref_wait++;
      if (!ref_owned) begin
        if (e1 && m1_lock && MB > 1) begin ref_owned = 1; ref_beats = 1; end
      end else begin
        if (e1) ref_beats++;
        if (!m1_req || !m1_lock || ref_beats >= MB) begin ref_owned = 0; ref_beats = 0; end
      end
    end
    if (e0 && m0_we) ref_mem[int'(m0_addr)] = m0_wdata;
    if (e1 && m1_we) ref_mem[int'(m1_addr)] = m1_wdata;
    @(negedge clk);
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic r1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic lk);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_lock = lk;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if ({dut.state, dut.starve_cnt, dut.beat_cnt} !== 13'd0) begin
      fails++; $display("FAIL reset_state got st=%0d sc=%0d bc=%0d want 0", dut.state, dut.starve_cnt, dut.beat_cnt);
    end
    tests_run++;
    if ({m0_rvalid, m1_rvalid, m0_gnt, m1_gnt, ram_en, ram_we, core_stall} !== 7'd0) begin
      fails++; $display("FAIL reset_outputs got %b want 0", {m0_rvalid, m1_rvalid, m0_gnt, m1_gnt, ram_en, ram_we, core_stall});
    end
    tick();
  endtask

  task automatic test_m0_read();
    drive(1, 1, 12'h010, 64'hA5, 0, 0, '0, '0, 0);
    tick();
    drive(1, 0, 12'h010, '0, 0, 0, '0, '0, 0);
    #1;
    tests_run++;
    if ({m0_gnt, m1_gnt, ram_en, ram_we, ram_addr} !== {4'b1010, 12'h010}) begin
      fails++; $display("FAIL m0_read_cmd got gnt=%b%b en=%b we=%b addr=%h want 1 0 1 0 010", m0_gnt, m1_gnt, ram_en, ram_we, ram_addr);
    end
    tick();
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
    #1;
    tests_run++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 64'hA5}) begin
      fails++; $display("FAIL m0_read_data got rv=%b data=%h want 1 a5", m0_rvalid, m0_rdata);
    end
    tick();
  endtask

  task automatic test_starvation();
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 12'h100, '0, 1, 0, 12'h200, '0, 0);
      #1;
      tests_run++;
      if ({m0_gnt, m1_gnt, core_stall} !== {k != 4, k == 4, k == 4}) begin
        fails++; $display("FAIL starve_cycle%0d got m0=%b m1=%b stall=%b want %b %b %b",
                          k, m0_gnt, m1_gnt, core_stall, k != 4, k == 4, k == 4);
      end
      tick();
    end
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
    tick();
  endtask

  task automatic test_lock_burst();
    for (int k = 0; k < 13; k++) begin
      drive(1, 0, 12'h101, '0, 1, 0, 12'h201, '0, 1);
      #1;
      tests_run++;
      if ({m0_gnt, m1_gnt, core_stall} !== {!(k >= 4 && k < 12), k >= 4 && k < 12, k >= 4 && k < 12}) begin
        fails++; $display("FAIL burst_cycle%0d got m0=%b m1=%b stall=%b", k, m0_gnt, m1_gnt, core_stall);
      end
      tick();
    end
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
    tick();
  endtask

  task automatic test_write_then_read();
    drive(1, 1, 12'h020, 64'h1234, 0, 0, '0, '0, 0);
    tick();
    drive(0, 0, '0, '0, 1, 0, 12'h020, '0, 0);
    #1;
    tests_run++;
    if (m1_gnt !== 1'b1) begin
      fails++; $display("FAIL wr_rd_m1_gnt got %b want 1", m1_gnt);
    end
    tick();
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
    #1;
    tests_run++;
    if ({m1_rvalid, m1_rdata, m0_rvalid} !== {1'b1, 64'h1234, 1'b0}) begin
      fails++; $display("FAIL wr_rd_data got m1rv=%b data=%h m0rv=%b want 1 1234 0", m1_rvalid, m1_rdata, m0_rvalid);
    end
    tick();
  endtask

  task automatic test_reset_in_lock();
    drive(0, 0, '0, '0, 1, 0, 12'h020, '0, 1);
    tick();
    #1;
    tests_run++;
    if ({dut.state, m1_gnt} !== 2'b11) begin
      fails++; $display("FAIL lock_entry got st=%b gnt=%b want 1 1", dut.state, m1_gnt);
    end
    tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if (m1_rvalid !== 1'b1) begin
      fails++; $display("FAIL lock_read_rv got %b want 1", m1_rvalid);
    end
    tick();
    rst = 1'b0;
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
    #1;
    tests_run++;
    if ({m1_rvalid, dut.state, dut.starve_cnt, dut.beat_cnt} !== 14'd0) begin
      fails++; $display("FAIL rst_in_lock got rv=%b st=%b sc=%0d bc=%0d want 0", m1_rvalid, dut.state, dut.starve_cnt, dut.beat_cnt);
    end
    tick();
  endtask

  task automatic test_idle();
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
    for (int k = 0; k < 10; k++) begin
      #1;
      tests_run++;
      if ({ram_en, ram_we, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dut.starve_cnt, dut.beat_cnt} !== 18'd0) begin
        fails++; $display("FAIL idle_cycle%0d got en=%b gnt=%b%b rv=%b%b sc=%0d bc=%0d", k, ram_en, m0_gnt, m1_gnt,
                          m0_rvalid, m1_rvalid, dut.starve_cnt, dut.beat_cnt);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [210:0] obs, exp;
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
    e0 = 0; e1 = 0;
    for (int k = 0; k < 400; k++) begin
      // A pending, ungranted command must stay put
      if (!m0_req || e0) begin
        m0_req = ($urandom_range(0, 2) != 0);
        m0_we = ($urandom_range(0, 1) == 1);
        m0_addr = AW'($urandom_range(0, 15));
        m0_wdata = {$urandom, $urandom};
      end
      if (!m1_req || e1) begin
        m1_req = ($urandom_range(0, 1) == 1);
        m1_we = ($urandom_range(0, 1) == 1);
        m1_addr = AW'($urandom_range(0, 15));
        m1_wdata = {$urandom, $urandom};
      end
      m1_lock = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      #1;
      model_eval();
      obs = {m0_gnt, m1_gnt, ram_en, ram_we, ram_addr, ram_wdata, core_stall, m0_rvalid, m0_rdata, m1_rvalid, m1_rdata};
      exp = {e0, e1, x_en, x_we, x_addr, x_wdata, x_stall, x_rv0, x_rd0, x_rv1, x_rd1};
      tests_run++;
      if (obs !== exp) begin
        fails++; $display("FAIL random_cycle%0d got %h want %h", k, obs, exp);
      end
      tick();
    end
    rst = 1'b0;
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
    tick();
  endtask

  initial begin
    ref_wait = 0; ref_owned = 0; ref_beats = 0;
    x_rv0 = 0; x_rv1 = 0; x_rd0 = '0; x_rd1 = '0;
    rst = 1'b1;
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
    @(negedge clk);
    test_reset();
    test_m0_read();
    test_starvation();
    test_lock_burst();
    test_write_then_read();
    test_reset_in_lock();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
